score_fnd_scan: RTL
===================

SCORE_FND_SCAN -- requirements
Module: score_fnd_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000; clock cycles each digit is lit (minimum 2).
REQ-002 SHALL have parameter BLINK_FRAMES, default 64; scan frames per blink half-period (minimum 1).
REQ-003 SHALL have port clk, input, 1 bit; single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port digit_one, input, 4 bits; ones digit code, 0-9 numeral, 10-15 blank.
REQ-006 SHALL have port digit_ten, input, 4 bits; tens digit code, same coding.
REQ-007 SHALL have port digit_hun, input, 4 bits; hundreds digit code, same coding.
REQ-008 SHALL have port blink_en, input, 1 bit; 1 = flash whole display.
REQ-009 SHALL have port seg_out, output, 8 bits; active-high segments, bit0=a ... bit6=g, bit7=dp.
REQ-010 SHALL have port com_out, output, 3 bits; active-low digit enables, bit0=ones, bit1=tens, bit2=hundreds.
REQ-011 SHALL have port frame_tick, output, 1 bit; one-cycle pulse at each frame boundary.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; scan_tick = (count == SCAN_DIV-1).
REQ-013 Digit index SHALL advance 0->1->2->0 on each scan_tick edge; index 0=ones, 1=tens, 2=hundreds.
REQ-014 Exactly one com_out bit SHALL be low at all times: 110, 101, 011 for index 0, 1, 2.
REQ-015 The three digit inputs SHALL be captured into shadow registers only on the edge where index wraps 2->0; mid-frame input changes are not displayed until the next wrap.
REQ-016 frame_tick SHALL be high for exactly the one cycle following the wrap edge; it SHALL be low at all other times.
REQ-017 seg_out and com_out SHALL be registered and SHALL update on the same edge as the index.
REQ-018 On the wrap edge, seg_out for index 0 SHALL use the value being captured, not the stale shadow.
REQ-019 Decode (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; codes 10-15 = 00.
REQ-020 seg_out bit7 (dp) SHALL always be 0.
REQ-021 While blink_en=1, the frame counter SHALL count wraps 0..BLINK_FRAMES-1 and toggle blink_phase at its terminal count.
REQ-022 While blink_en=1 and blink_phase=1, seg_out SHALL be 00; com_out SHALL continue scanning.
REQ-023 While blink_en=0, the frame counter and blink_phase SHALL be held at 0 and the digits SHALL be shown normally.
REQ-024 When blink_en falls, seg_out SHALL resume the decoded value on the next clock edge.
REQ-025 When blink_en rises, the display SHALL stay visible for BLINK_FRAMES full frames before the first dark period.
REQ-026 Inputs are sampled only at the wrap edge, so all three displayed digits always come from the same capture; no mixed-frame display.

Reset
REQ-027 While rst_n=0, the following SHALL hold: prescaler=0; index=0; shadows=10 (blank); frame counter=0; blink_phase=0.
REQ-028 While rst_n=0, the outputs SHALL be: seg_out=00, com_out=110, frame_tick=0.
REQ-029 Reset assertion mid-frame SHALL take effect immediately, without a clock edge.
REQ-030 After rst_n rises, the first index advance SHALL occur on edge SCAN_DIV.
REQ-031 The display SHALL show blank until the first wrap following reset release.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-032 Reset scenario: release rst_n with inputs 1/2/3 -> seg_out=00, com_out=110 for 4 cycles, then 101, then 011.
REQ-033 Capture scenario: hun=1, ten=2, one=3 held -> after the first wrap, frame_tick pulses once; then seg_out = 4F@110, 5B@101, 06@011, repeating every 12 cycles.
REQ-034 Blank scenario: hun=10, ten=0, one=7 -> seg_out = 07@110, 3F@101, 00@011.
REQ-035 Tearing scenario: change one 3->9 mid-frame -> the ones slot stays 4F until the next wrap, then shows 6F.
REQ-036 Blink scenario: blink_en=1 from a wrap -> 2 frames visible, 2 frames seg_out=00 while com_out keeps scanning, repeating; dropping blink_en while dark -> decoded value next edge.
REQ-037 Async reset scenario: pulse rst_n low for a partial cycle mid-frame -> outputs immediately 00/110, frame_tick=0, shadows blank after release.

Source files
------------

// File: rtl/score_fnd_scan.sv
// Three-digit multiplexed 7-segment scanner with frame-locked input capture
// and optional whole-display blink.
module score_fnd_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_one,
  input  logic [3:0] digit_ten,
  input  logic [3:0] digit_hun,
  input  logic       blink_en,
  output logic [7:0] seg_out,
  output logic [2:0] com_out,
  output logic       frame_tick
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [3:0]    BLANK    = 4'd10;

  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [3:0]    sh_one, sh_ten, sh_hun;
  logic [FW-1:0] fcnt;
  logic          phase;
  logic [7:0]    seg_raw;

  logic          scan_tick, wrap;
  logic [1:0]    idx_nxt;
  logic [3:0]    code_nxt;
  logic [2:0]    com_nxt;
  logic [7:0]    seg_nxt;
  logic [FW-1:0] fcnt_nxt;
  logic          phase_nxt;

  function automatic logic [7:0] decode(input logic [3:0] c);
    logic [7:0] s;
    case (c)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  assign scan_tick = (pre == PRE_LAST);
  assign wrap      = scan_tick && (idx == 2'd2);

  always_comb begin
    idx_nxt = idx;
    if (scan_tick)
      idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  end

  // On the wrap edge the ones slot shows the value being captured
  always_comb begin
    code_nxt = BLANK;
    com_nxt  = 3'b110;
    unique case (1'b1)
      (idx_nxt == 2'd0): begin
        code_nxt = wrap ? digit_one : sh_one;
        com_nxt  = 3'b110;
      end
      (idx_nxt == 2'd1): begin
        code_nxt = sh_ten;
        com_nxt  = 3'b101;
      end
      default: begin
        code_nxt = sh_hun;
        com_nxt  = 3'b011;
      end
    endcase
  end

  always_comb begin
    seg_nxt   = scan_tick ? decode(code_nxt) : seg_raw;
    fcnt_nxt  = '0;
    phase_nxt = 1'b0;
    if (blink_en) begin
      fcnt_nxt  = fcnt;
      phase_nxt = phase;
      if (wrap) begin
        fcnt_nxt = (fcnt == FRM_LAST) ? '0 : fcnt + FW'(1);
        if (fcnt == FRM_LAST)
          phase_nxt = ~phase;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      idx        <= 2'd0;
      sh_one     <= BLANK;
      sh_ten     <= BLANK;
      sh_hun     <= BLANK;
      fcnt       <= '0;
      phase      <= 1'b0;
      seg_raw    <= 8'h00;
      seg_out    <= 8'h00;
      com_out    <= 3'b110;
      frame_tick <= 1'b0;
    end else begin
      pre        <= scan_tick ? '0 : pre + PW'(1);
      idx        <= idx_nxt;
      fcnt       <= fcnt_nxt;
      phase      <= phase_nxt;
      seg_raw    <= seg_nxt;
      seg_out    <= (blink_en && phase_nxt) ? 8'h00 : seg_nxt;
      com_out    <= com_nxt;
      frame_tick <= wrap;
      if (wrap) begin
        sh_one <= digit_one;
        sh_ten <= digit_ten;
        sh_hun <= digit_hun;
      end
    end
  end

endmodule
